// File: rtl/aes_ctrl_pkg.sv
// Shared control definitions for the iterative AES round datapath:
// key-size encodings, round counts and the scheduler state type.
package aes_ctrl_pkg;

   localparam int ROUND_IDX_W = 4;

   localparam logic [1:0] KEY128 = 2'b00;
   localparam logic [1:0] KEY192 = 2'b01;
   localparam logic [1:0] KEY256 = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      ROUND,
      DONE
   } state_t;

   // Both 2'b10 and 2'b11 select a 256-bit key, hence the default arm.
   function automatic logic [ROUND_IDX_W-1:0] nr_of(input logic [1:0] sel);
      case (sel)
         KEY128:  return 4'd10;
         KEY192:  return 4'd12;
         default: return 4'd14;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr,
// wrapping. The caller owns and advances the pointer.
module rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [1:0]         ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [1:0]         grantIdx,
   output logic               anyValid
);

   // Scan offsets from the pointer outward; the first hit wins and blocks the rest.
   always_comb begin
      grant    = '0;
      grantIdx = '0;
      anyValid = 1'b0;
      for (int off = 0; off < NUM_REQ; off++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!anyValid && valid[i] && (i == (int'(ptr) + off) % NUM_REQ)) begin
               grant[i] = 1'b1;
               grantIdx = 2'(i);
               anyValid = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/aes_round_scheduler.sv
// Round-robin job arbiter and round sequencer for one shared AES round
// datapath: load, Nr rounds, then a response handshake to the owner.
module aes_round_scheduler #(
   parameter int NUM_REQ = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [2*NUM_REQ-1:0] req_sel,
   input  logic [NUM_REQ-1:0]   req_decrypt,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   resp_valid,
   input  logic [NUM_REQ-1:0]   resp_ready,
   output logic                 dp_load,
   output logic                 dp_round_en,
   output logic [3:0]           dp_round_idx,
   output logic                 dp_final,
   output logic                 dp_decrypt,
   output logic [1:0]           dp_sel,
   output logic [1:0]           grant_id,
   output logic                 busy
);

   import aes_ctrl_pkg::*;

   state_t                 state, stateNext;
   logic [ROUND_IDX_W-1:0] roundCnt, roundCntNext;
   logic [1:0]             rrPtr;
   logic [NUM_REQ-1:0]     winGrant;
   logic [1:0]             winIdx;
   logic                   anyValid;
   logic [1:0]             winSel;
   logic                   winDec;
   logic                   accept;
   logic                   lastIdx;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) arbiter (
      .valid    (req_valid),
      .ptr      (rrPtr),
      .grant    (winGrant),
      .grantIdx (winIdx),
      .anyValid (anyValid)
   );

   // Pull the winning requester's job parameters out of the flat input buses.
   always_comb begin
      winSel = '0;
      winDec = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winGrant[i]) begin
            winSel = req_sel[2*i +: 2];
            winDec = req_decrypt[i];
         end
      end
   end

   // Encrypt ends on index Nr, decrypt on index 0; Nr comes from the latched key size.
   assign lastIdx = dp_decrypt ? (roundCnt == '0) : (roundCnt == nr_of(dp_sel));

   // Next-state and per-cycle datapath controls; roundCnt holds the index for the next round.
   always_comb begin
      stateNext    = state;
      roundCntNext = roundCnt;
      req_ready    = '0;
      resp_valid   = '0;
      dp_load      = 1'b0;
      dp_round_en  = 1'b0;
      dp_round_idx = '0;
      dp_final     = 1'b0;
      accept       = 1'b0;
      case (state)
         IDLE: begin
            if (enable && !reset && anyValid) begin
               accept       = 1'b1;
               req_ready    = winGrant;
               dp_load      = 1'b1;
               dp_round_idx = winDec ? nr_of(winSel) : '0;
               roundCntNext = winDec ? nr_of(winSel) - 4'd1 : 4'd1;
               stateNext    = ROUND;
            end
         end
         ROUND: begin
            dp_round_idx = roundCnt;
            if (enable) begin
               dp_round_en = 1'b1;
               dp_final    = lastIdx;
               if (lastIdx) begin
                  stateNext = DONE;
               end else begin
                  roundCntNext = dp_decrypt ? roundCnt - 4'd1 : roundCnt + 4'd1;
               end
            end
         end
         DONE: begin
            for (int i = 0; i < NUM_REQ; i++) begin
               if (2'(i) == grant_id) begin
                  resp_valid[i] = 1'b1;
                  if (resp_ready[i]) begin
                     stateNext = IDLE;
                  end
               end
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // Job parameters and the round-robin pointer only move on an accepted request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         roundCnt   <= '0;
         rrPtr      <= '0;
         grant_id   <= '0;
         dp_sel     <= '0;
         dp_decrypt <= 1'b0;
      end else begin
         state    <= stateNext;
         roundCnt <= roundCntNext;
         if (accept) begin
            grant_id   <= winIdx;
            dp_sel     <= winSel;
            dp_decrypt <= winDec;
            rrPtr      <= (winIdx == 2'(NUM_REQ - 1)) ? 2'd0 : winIdx + 2'd1;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Directed bench for aes_round_scheduler with two requesters: a vector table
// for single jobs plus sequences for arbitration, stalls, backpressure and reset.
module tb_aes_round_scheduler;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [1:0] reqValid;
   logic [3:0] reqSel;
   logic [1:0] reqDecrypt;
   logic [1:0] reqReady;
   logic [1:0] respValid;
   logic [1:0] respReady;
   logic       dpLoad;
   logic       dpRoundEn;
   logic [3:0] dpRoundIdx;
   logic       dpFinal;
   logic       dpDecrypt;
   logic [1:0] dpSel;
   logic [1:0] grantId;
   logic       busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0] valid;
      logic [3:0] sel;
      logic [1:0] dec;
      logic       en;
      logic [1:0] rr;
      logic [1:0] expReady;
      logic [1:0] expResp;
      logic       expLoad;
      logic       expRoundEn;
      logic [3:0] expIdx;
      logic       expFinal;
      logic       expBusy;
   } vec_t;

   vec_t vecs[$];

   aes_round_scheduler #(.NUM_REQ(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .req_valid    (reqValid),
      .req_sel      (reqSel),
      .req_decrypt  (reqDecrypt),
      .req_ready    (reqReady),
      .resp_valid   (respValid),
      .resp_ready   (respReady),
      .dp_load      (dpLoad),
      .dp_round_en  (dpRoundEn),
      .dp_round_idx (dpRoundIdx),
      .dp_final     (dpFinal),
      .dp_decrypt   (dpDecrypt),
      .dp_sel       (dpSel),
      .grant_id     (grantId),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs are driven just after the rising edge and outputs sampled on the falling edge.
   task automatic applyStimulus(input logic [1:0] v, input logic [3:0] s, input logic [1:0] d,
                                input logic en, input logic [1:0] rr);
      reqValid   = v;
      reqSel     = s;
      reqDecrypt = d;
      enable     = en;
      respReady  = rr;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [1:0] rdy, input logic [1:0] rv,
                              input logic ld, input logic ren, input logic [3:0] idx,
                              input logic fin, input logic bsy);
      check({tag, ".req_ready"},    32'(reqReady),   32'(rdy));
      check({tag, ".resp_valid"},   32'(respValid),  32'(rv));
      check({tag, ".dp_load"},      32'(dpLoad),     32'(ld));
      check({tag, ".dp_round_en"},  32'(dpRoundEn),  32'(ren));
      check({tag, ".dp_round_idx"}, 32'(dpRoundIdx), 32'(idx));
      check({tag, ".dp_final"},     32'(dpFinal),    32'(fin));
      check({tag, ".busy"},         32'(busy),       32'(bsy));
   endtask

   task automatic addVec(input logic [1:0] v, input logic [3:0] s, input logic [1:0] d,
                         input logic en, input logic [1:0] rr, input logic [1:0] rdy,
                         input logic [1:0] rv, input logic ld, input logic ren,
                         input logic [3:0] idx, input logic fin, input logic bsy);
      vec_t x;
      x.valid = v;   x.sel = s;       x.dec = d;      x.en = en;        x.rr = rr;
      x.expReady = rdy; x.expResp = rv; x.expLoad = ld; x.expRoundEn = ren;
      x.expIdx = idx; x.expFinal = fin; x.expBusy = bsy;
      vecs.push_back(x);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int accepts;
      int lastAccept;
      int expIdx;
      logic [3:0] eIdx;
      logic en;

      reset = 1'b1;
      applyStimulus(2'b00, 4'b0000, 2'b00, 1'b0, 2'b00);
      #3;
      check("reset.busy", 32'(busy), 32'd0);
      check("reset.grant_id", 32'(grantId), 32'd0);
      check("reset.dp_sel", 32'(dpSel), 32'd0);
      check("reset.dp_decrypt", 32'(dpDecrypt), 32'd0);
      check("reset.resp_valid", 32'(respValid), 32'd0);
      nextCycle();
      reset = 1'b0;

      // 128-bit encrypt by req0: load at idx 0, rounds 1..10, response at cycle 11.
      addVec(2'b01, 4'b0000, 2'b00, 1, 2'b01, 2'b01, 2'b00, 1, 0, 4'd0, 0, 0);
      for (int c = 1; c <= 10; c++)
         addVec(2'b00, 4'b0000, 2'b00, 1, 2'b01, 2'b00, 2'b00, 0, 1, 4'(c), c == 10, 1);
      addVec(2'b00, 4'b0000, 2'b00, 1, 2'b01, 2'b00, 2'b01, 0, 0, 4'd0, 0, 1);
      // 256-bit decrypt by req1 (sel 11): load at idx 14, rounds 13..0; inputs change after accept.
      addVec(2'b10, 4'b1100, 2'b10, 1, 2'b10, 2'b10, 2'b00, 1, 0, 4'd14, 0, 0);
      for (int c = 1; c <= 14; c++)
         addVec(2'b00, 4'b0000, 2'b00, 1, 2'b10, 2'b00, 2'b00, 0, 1, 4'(14 - c), c == 14, 1);
      addVec(2'b00, 4'b0000, 2'b00, 1, 2'b10, 2'b00, 2'b10, 0, 0, 4'd0, 0, 1);
      addVec(2'b00, 4'b0000, 2'b00, 1, 2'b10, 2'b00, 2'b00, 0, 0, 4'd0, 0, 0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].valid, vecs[i].sel, vecs[i].dec, vecs[i].en, vecs[i].rr);
         @(negedge clk);
         checkOutput($sformatf("vec%0d", i), vecs[i].expReady, vecs[i].expResp, vecs[i].expLoad,
                     vecs[i].expRoundEn, vecs[i].expIdx, vecs[i].expFinal, vecs[i].expBusy);
         nextCycle();
      end
      check("dec.grant_id", 32'(grantId), 32'd1);
      check("dec.dp_sel", 32'(dpSel), 32'd3);
      check("dec.dp_decrypt", 32'(dpDecrypt), 32'd1);

      // Both requesters continuously valid, 192-bit encrypt: grants alternate 0,1,0,1.
      applyStimulus(2'b11, 4'b0101, 2'b00, 1'b1, 2'b11);
      accepts = 0;
      lastAccept = 0;
      expIdx = 1;
      for (int cyc = 0; cyc < 80 && accepts < 4; cyc++) begin
         @(negedge clk);
         if (dpLoad) begin
            check($sformatf("rr.ready%0d", accepts), 32'(reqReady), (accepts % 2 == 0) ? 32'd1 : 32'd2);
            if (accepts > 0)
               check($sformatf("rr.spacing%0d", accepts), 32'(cyc - lastAccept), 32'd14);
            lastAccept = cyc;
            accepts++;
            expIdx = 1;
         end else if (dpRoundEn) begin
            if (expIdx == 1)
               check($sformatf("rr.grant_id%0d", accepts), 32'(grantId), 32'((accepts - 1) % 2));
            check($sformatf("rr.idx%0d", expIdx), 32'(dpRoundIdx), 32'(expIdx));
            check($sformatf("rr.final%0d", expIdx), 32'(dpFinal), 32'(expIdx == 12));
            expIdx++;
         end
         nextCycle();
      end
      check("rr.accepts", 32'(accepts), 32'd4);
      applyStimulus(2'b00, 4'b0000, 2'b00, 1'b1, 2'b11);
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (!busy) break;
         nextCycle();
      end
      check("rr.drain_busy", 32'(busy), 32'd0);
      nextCycle();

      // 128-bit encrypt by req0 with enable low for three cycles at round 5.
      for (int c = 0; c <= 15; c++) begin
         en = !(c >= 5 && c <= 7);
         applyStimulus((c == 0) ? 2'b01 : 2'b00, 4'b0000, 2'b00, en, 2'b01);
         @(negedge clk);
         eIdx = (c < 5) ? 4'(c) : (c <= 8) ? 4'd5 : (c <= 13) ? 4'(c - 3) : 4'd0;
         if (c == 0)
            checkOutput("stall0", 2'b01, 2'b00, 1, 0, 4'd0, 0, 0);
         else if (c <= 13)
            checkOutput($sformatf("stall%0d", c), 2'b00, 2'b00, 0, en, eIdx, c == 13, 1);
         else if (c == 14)
            checkOutput("stall14", 2'b00, 2'b01, 0, 0, 4'd0, 0, 1);
         else
            checkOutput("stall15", 2'b00, 2'b00, 0, 0, 4'd0, 0, 0);
         nextCycle();
      end

      // req1 wins (pointer at 1); resp_ready held low 5 cycles while req0 keeps asking.
      for (int c = 0; c <= 24; c++) begin
         applyStimulus(2'b11, 4'b0000, 2'b00, 1'b1, (c == 16) ? 2'b10 : 2'b00);
         @(negedge clk);
         if (c == 0)
            checkOutput("bp0", 2'b10, 2'b00, 1, 0, 4'd0, 0, 0);
         else if (c <= 10)
            checkOutput($sformatf("bp%0d", c), 2'b00, 2'b00, 0, 1, 4'(c), c == 10, 1);
         else if (c <= 16)
            checkOutput($sformatf("bp%0d", c), 2'b00, 2'b10, 0, 0, 4'd0, 0, 1);
         else if (c == 17)
            checkOutput("bp17", 2'b01, 2'b00, 1, 0, 4'd0, 0, 0);
         else
            checkOutput($sformatf("bp%0d", c), 2'b00, 2'b00, 0, 1, 4'(c - 17), 0, 1);
         if (c < 24)
            nextCycle();
      end
      check("bp.grant_id", 32'(grantId), 32'd0);

      // Reset during round 7 of req0's job: outputs clear immediately, job is abandoned.
      reset = 1'b1;
      #1;
      checkOutput("rst", 2'b00, 2'b00, 0, 0, 4'd0, 0, 0);
      check("rst.grant_id", 32'(grantId), 32'd0);
      check("rst.dp_sel", 32'(dpSel), 32'd0);
      nextCycle();
      reset = 1'b0;
      applyStimulus(2'b00, 4'b0000, 2'b00, 1'b1, 2'b11);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         check($sformatf("rst.no_resp%0d", k), 32'(respValid), 32'd0);
         nextCycle();
      end
      applyStimulus(2'b11, 4'b0000, 2'b00, 1'b1, 2'b11);
      @(negedge clk);
      checkOutput("rst.regrant", 2'b01, 2'b00, 1, 0, 4'd0, 0, 0);
      nextCycle();
      applyStimulus(2'b00, 4'b0000, 2'b00, 1'b1, 2'b11);
      @(negedge clk);
      check("rst.regrant_id", 32'(grantId), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
